// File: rtl/pe_pkg.sv
// Shared widths, drain-state encoding and saturating arithmetic helpers
// for the systolic MAC processing element.
package pe_pkg;

    localparam int PE_DATA_W = 16;
    localparam int PE_ACC_W  = 40;
    localparam int PE_FRAC_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        LOCAL = 1'b1
    } drain_st_t;

    // Helpers work on 64-bit carriers so any ACC_W up to 62 fits.
    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        return sat_clamp(a + b, w);
    endfunction

    function automatic logic signed [63:0] rnd_shift(
        input logic signed [63:0] x,
        input int                 frac
    );
        return (x + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    function automatic logic signed [63:0] rnd_sat(
        input logic signed [63:0] x,
        input int                 frac,
        input int                 w
    );
        return sat_clamp(rnd_shift(x, frac), w);
    endfunction

endpackage

// File: rtl/pe_mac_drain_requant.sv
// Round-half-up and saturate an accumulator down to the output width.
module pe_requant
    import pe_pkg::*;
#(
    parameter int ACC_W  = PE_ACC_W,
    parameter int DATA_W = PE_DATA_W,
    parameter int FRAC_W = PE_FRAC_W
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] q,
    output logic                     sat
);

    logic signed [63:0] t;

    always_comb begin
        t   = rnd_shift(64'(acc), FRAC_W);
        q   = DATA_W'(rnd_sat(64'(acc), FRAC_W, DATA_W));
        sat = 64'(q) != t;
    end

endmodule

// File: rtl/pe_mac_drain.sv
// Output-stationary systolic PE: operand forwarding, saturating MAC,
// requantization and a single-entry valid/ready drain chain stage.
module pe_mac_drain
    import pe_pkg::*;
#(
    parameter int DATA_W    = PE_DATA_W,
    parameter int ACC_W     = PE_ACC_W,
    parameter int FRAC_W    = PE_FRAC_W,
    parameter int MULT_PIPE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_last,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    input  logic              drain_in_valid,
    input  logic [DATA_W-1:0] drain_in_data,
    output logic              drain_in_ready,
    output logic              drain_out_valid,
    output logic [DATA_W-1:0] drain_out_data,
    input  logic              drain_out_ready,
    output logic              sat_flag,
    output logic              ovr_flag
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] pp;
    logic                       pv;
    logic                       pf;
    logic                       pl;

    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_nxt;
    logic signed [63:0]         base;
    logic signed [63:0]         raw;
    logic signed [63:0]         sum;
    logic                       acc_sat;
    logic signed [DATA_W-1:0]   q;
    logic                       q_sat;

    logic [DATA_W-1:0]          res;
    drain_st_t                  st;
    drain_st_t                  st_nxt;
    logic                       fin;
    logic                       loadable;
    logic                       move;
    logic                       res_load;
    logic                       ovr;
    logic                       take_up;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
        end else begin
            out_valid <= in_valid;
            out_first <= in_first;
            out_last  <= in_last;
            out_a     <= in_a;
            out_b     <= in_b;
        end
    end

    assign prod = $signed(in_a) * $signed(in_b);

    generate
        if (MULT_PIPE != 0) begin : g_pipe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv <= 1'b0;
                    pf <= 1'b0;
                    pl <= 1'b0;
                    pp <= '0;
                end else begin
                    pv <= in_valid;
                    pf <= in_first;
                    pl <= in_last;
                    pp <= prod;
                end
            end
        end else begin : g_comb
            assign pv = in_valid;
            assign pf = in_first;
            assign pl = in_last;
            assign pp = prod;
        end
    endgenerate

    always_comb begin
        base    = pf ? 64'sd0 : 64'(acc);
        raw     = base + 64'(pp);
        sum     = sat_add(base, 64'(pp), ACC_W);
        acc_nxt = ACC_W'(sum);
        acc_sat = sum != raw;
    end

    pe_requant #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_requant (
        .acc (acc_nxt),
        .q   (q),
        .sat (q_sat)
    );

    assign fin      = pv & pl;
    assign loadable = !drain_out_valid || drain_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= EMPTY;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            EMPTY: if (fin) st_nxt = LOCAL;
            LOCAL: if (loadable && !fin) st_nxt = EMPTY;
            default: st_nxt = EMPTY;
        endcase
    end

    // A held result blocks upstream traffic until it has moved on.
    always_comb begin
        move           = (st == LOCAL) && loadable;
        res_load       = fin && ((st == EMPTY) || move);
        ovr            = fin && (st == LOCAL) && !loadable;
        drain_in_ready = loadable && (st == EMPTY);
        take_up        = drain_in_valid && drain_in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc             <= '0;
            res             <= '0;
            drain_out_valid <= 1'b0;
            drain_out_data  <= '0;
            sat_flag        <= 1'b0;
            ovr_flag        <= 1'b0;
        end else begin
            if (pv)
                acc <= acc_nxt;
            if (res_load)
                res <= q;
            if (move) begin
                drain_out_valid <= 1'b1;
                drain_out_data  <= res;
            end else if (take_up) begin
                drain_out_valid <= 1'b1;
                drain_out_data  <= drain_in_data;
            end else if (drain_out_ready) begin
                drain_out_valid <= 1'b0;
            end
            sat_flag <= sat_flag | (pv & acc_sat) | (fin & q_sat);
            ovr_flag <= ovr_flag | ovr;
        end
    end

endmodule

// File: tb/tb_pe_mac_drain.sv
// Scoreboarded random and directed bench for the MAC/drain PE.
module tb_pe_mac_drain;

    localparam int DW  = 16;
    localparam int MP  = 0;
    localparam int LAT = 2 + MP;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_first, in_last;
    logic [DW-1:0] in_a, in_b;
    logic          out_valid, out_first, out_last;
    logic [DW-1:0] out_a, out_b;
    logic          drain_in_valid;
    logic [DW-1:0] drain_in_data;
    logic          drain_in_ready;
    logic          drain_out_valid;
    logic [DW-1:0] drain_out_data;
    logic          drain_out_ready;
    logic          sat_flag, ovr_flag;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] sb[$];
    longint        macc     = 0;
    bit            exp_sat  = 1'b0;
    bit            rnd_rdy  = 1'b0;

    pe_mac_drain #(
        .DATA_W    (DW),
        .ACC_W     (40),
        .FRAC_W    (8),
        .MULT_PIPE (MP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_first        (in_first),
        .in_last         (in_last),
        .in_a            (in_a),
        .in_b            (in_b),
        .out_valid       (out_valid),
        .out_first       (out_first),
        .out_last        (out_last),
        .out_a           (out_a),
        .out_b           (out_b),
        .drain_in_valid  (drain_in_valid),
        .drain_in_data   (drain_in_data),
        .drain_in_ready  (drain_in_ready),
        .drain_out_valid (drain_out_valid),
        .drain_out_data  (drain_out_data),
        .drain_out_ready (drain_out_ready),
        .sat_flag        (sat_flag),
        .ovr_flag        (ovr_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic longint clampw(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // One clock; also checks the forward path against what was driven.
    task automatic cyc();
        logic [2*DW+2:0] fw;
        logic            r0;
        fw = {in_valid, in_first, in_last, in_a, in_b};
        r0 = rst;
        if (rnd_rdy) drain_out_ready = ($urandom % 10) < 7;
        @(posedge clk);
        #1;
        if (!r0 && !rst)
            chk("fwd", {out_valid, out_first, out_last, out_a, out_b}, fw);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input bit f, input bit l, input bit keep);
        longint t;
        longint c;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = f;
        in_last  = l;
        if (f) macc = 0;
        t = macc + longint'($signed(a)) * longint'($signed(b));
        c = clampw(t, 40);
        if (c != t) exp_sat = 1'b1;
        macc = c;
        if (l) begin
            t = (macc + 128) >>> 8;
            c = clampw(t, DW);
            if (c != t) exp_sat = 1'b1;
            if (keep) sb.push_back(DW'(c));
        end
        cyc();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_all();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            cyc();
            k++;
        end
        chk("drained", sb.size(), 0);
    endtask

    function automatic logic [DW-1:0] gen();
        if ($urandom % 2) return DW'($urandom);
        return DW'($urandom_range(0, 511) - 256);
    endfunction

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    logic [DW-1:0] hold_d;
    bit            hold_v = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("stall_hold", {drain_out_valid, drain_out_data},
                    {1'b1, hold_d});
            if (drain_out_valid && drain_out_ready) begin
                if (sb.size() == 0)
                    chk("unexpected_out", drain_out_data, 64'hdead_0000);
                else
                    chk("drain_data", drain_out_data, sb.pop_front());
            end
            hold_v = drain_out_valid && !drain_out_ready;
            hold_d = drain_out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {in_valid, in_first, in_last, in_a, in_b} = '0;
        drain_in_valid  = 1'b0;
        drain_in_data   = '0;
        drain_out_ready = 1'b0;
        #13;
        chk("reset_state", {out_valid, out_first, out_last, out_a, out_b,
            drain_out_valid, drain_out_data, sat_flag, ovr_flag}, 0);
        cyc();
        rst = 1'b0;
        idle(2);

        // Forwarding, then asynchronous reset between edges.
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'hABCD;
        cyc();
        chk("fwd_direct", {out_valid, out_a, out_b}, {1'b1, 16'h1234, 16'hABCD});
        {in_valid, in_a, in_b} = '0;
        #2 rst = 1'b1;
        #1 chk("async_rst_fwd", {out_valid, out_a, out_b}, 0);
        cyc();
        rst  = 1'b0;
        macc = 0;
        idle(1);

        // Four-beat dot product and result latency.
        drain_out_ready = 1'b1;
        beat(16'h0100, 16'h0200, 1, 0, 1);
        beat(16'h0100, 16'h0200, 0, 0, 1);
        beat(16'h0100, 16'h0200, 0, 0, 1);
        beat(16'h0100, 16'h0200, 0, 1, 1);
        for (int i = 1; i < LAT; i++) begin
            chk("lat_early", drain_out_valid, 0);
            cyc();
        end
        chk("lat_valid", {drain_out_valid, drain_out_data}, {1'b1, 16'h0800});
        idle(3);

        // Rounding and sign.
        beat(16'h0001, 16'h0080, 1, 1, 1);
        beat(16'hFFFF, 16'h0080, 1, 1, 1);
        beat(16'hFFFF, 16'hFF80, 1, 1, 1);
        idle(4);
        chk("no_sat", sat_flag, 0);

        // Saturation.
        beat(16'h7FFF, 16'h7FFF, 1, 1, 1);
        idle(4);
        chk("sat_pos_flag", sat_flag, 1);
        beat(16'h8000, 16'h7FFF, 1, 1, 1);
        idle(4);
        drain_all();

        // Backpressure: A in output reg, B held locally, upstream 0x55 waiting.
        drain_out_ready = 1'b0;
        beat(16'h0300, 16'h0100, 1, 1, 1);
        idle(LAT);
        beat(16'h0500, 16'h0100, 1, 1, 1);
        idle(MP);
        drain_in_valid = 1'b1;
        drain_in_data  = 16'h0055;
        sb.push_back(16'h0055);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", {drain_out_valid, drain_out_data, drain_in_ready},
                {1'b1, 16'h0300, 1'b0});
            cyc();
        end
        drain_out_ready = 1'b1;
        cyc();
        chk("bp_local_next", drain_out_data, 16'h0500);
        cyc();
        drain_in_valid = 1'b0;
        chk("bp_upstream", drain_out_data, 16'h0055);
        drain_all();

        // Overflow: output full, one held, third result dropped.
        drain_out_ready = 1'b0;
        chk("ovr_clear", ovr_flag, 0);
        beat(16'h0200, 16'h0100, 1, 1, 1);
        idle(LAT);
        beat(16'h0400, 16'h0100, 1, 1, 1);
        beat(16'h0700, 16'h0100, 1, 1, 0);
        idle(LAT);
        chk("ovr_set", ovr_flag, 1);
        drain_out_ready = 1'b1;
        drain_all();

        // Reset mid-accumulation with a result stalled at the output.
        drain_out_ready = 1'b0;
        beat(16'h0100, 16'h0100, 1, 1, 1);
        idle(LAT);
        chk("pre_rst_valid", drain_out_valid, 1);
        beat(16'h1000, 16'h1000, 1, 0, 1);
        beat(16'h1000, 16'h1000, 0, 0, 1);
        #2 rst = 1'b1;
        #1 chk("async_rst_all", {out_valid, out_a, out_b, drain_out_valid,
            drain_out_data, sat_flag, ovr_flag}, 0);
        sb.delete();
        macc    = 0;
        exp_sat = 1'b0;
        cyc();
        rst = 1'b0;
        drain_out_ready = 1'b1;
        beat(16'h0100, 16'h0300, 0, 0, 1);
        beat(16'h0100, 16'h0100, 0, 1, 1);
        drain_all();

        // Random dot products with random backpressure.
        rnd_rdy = 1'b1;
        for (int d = 0; d < 40; d++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                idle($urandom_range(0, 2));
                if (j == n - 1) begin
                    int k;
                    k = 0;
                    while (sb.size() > 1 && k < 200) begin
                        cyc();
                        k++;
                    end
                    if (k == 200) chk("rnd_wait", sb.size(), 1);
                end
                beat(gen(), gen(), j == 0, j == n - 1, 1);
            end
        end
        rnd_rdy = 1'b0;
        drain_out_ready = 1'b1;
        drain_all();
        chk("rnd_sat_flag", sat_flag, exp_sat);
        chk("rnd_ovr_flag", ovr_flag, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_mac_drain.md
Name: pe_mac_drain

Overview:
- Parametrised output-stationary systolic processing element for the conv/GEMM array.
- Forwards A (east) and B (south) operands with valid, one register stage.
- Accumulates a signed fixed-point dot product framed by first/last markers.
- Requantizes the result (round, saturate) and shifts it out on a valid/ready drain chain through neighbouring PEs.

Parameters:
DATA_W, 16, signed operand width (A, B, output result)
ACC_W, 40, signed accumulator width; must be >= 2*DATA_W
FRAC_W, 8, fractional bits removed at requantization (arithmetic right shift); range 1..ACC_W-DATA_W
MULT_PIPE, 0, 1 inserts a product register (+1 cycle result latency)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand pair valid
in_first  in  1  first product of a dot product (qualified by in_valid)
in_last  in  1  last product of a dot product (qualified by in_valid)
in_a  in  DATA_W  signed operand A
in_b  in  DATA_W  signed operand B
out_valid  out  1  registered in_valid
out_first  out  1  registered in_first
out_last  out  1  registered in_last
out_a  out  DATA_W  registered in_a
out_b  out  DATA_W  registered in_b
drain_in_valid  in  1  upstream result valid
drain_in_data  in  DATA_W  upstream result
drain_in_ready  out  1  PE accepts upstream result
drain_out_valid  out  1  result valid toward array edge
drain_out_data  out  DATA_W  result
drain_out_ready  in  1  downstream accepts
sat_flag  out  1  sticky: accumulator or requantization saturated
ovr_flag  out  1  sticky: result dropped (local holding register still full)

Behaviour:
- Reset: all outputs, the accumulator, the result register, the output register and the sticky flags go to 0. Reset is asynchronous, so mid-operation reset discards any partial sum and held results immediately.
- Forward path:
  - out_* <= in_* every cycle, regardless of in_valid. Latency is 1.
  - The forward path never stalls.
- Product: p = in_a*in_b, full 2*DATA_W signed. With MULT_PIPE=1, p, valid, first and last are registered once before accumulation.
- Accumulate, on a valid product only:
  - acc <= (first ? 0 : acc) + sext(p).
  - The sum saturates to the ACC_W signed range, and sat_flag is set if it saturates.
  - No valid product: acc holds.
- Finalize, on a valid product with last:
  - q = (acc_next + 2^(FRAC_W-1)) >>> FRAC_W (round half up), then saturate to DATA_W signed. sat_flag is set if it clips.
  - first and last together = single-product result.
  - Result latency: res_valid high 1 cycle after the in_last edge (2 with MULT_PIPE=1).
- Local result register (res, res_valid):
  - Loaded by finalize.
  - If res_valid is still 1 at finalize time and is not being moved that same cycle, the new result is discarded and ovr_flag is set; the accumulator still restarts normally.
- Drain output register (single entry):
  - It is loadable when !drain_out_valid or drain_out_ready.
  - Source priority: local res first (then res_valid clears), otherwise upstream.
  - drain_in_ready = loadable && !res_valid.
  - An upstream beat is accepted only when drain_in_valid && drain_in_ready.
  - drain_out_valid/data remain stable while !drain_out_ready.
  - Local result reaches drain_out 1 cycle after res_valid if the register is free.
- Drain FSM states:
  - EMPTY to LOCAL when res is loaded.
  - LOCAL to EMPTY when res moves to the output register.
  - Upstream pass-through happens only in EMPTY.
  - Simultaneous finalize and res move: the move completes and the new res loads, so no overflow.
- Drain runs concurrently with accumulation of the next dot product.

Decomposition:
- Shared package pe_pkg:
  - default widths (DATA_W, ACC_W, FRAC_W)
  - sat_add helper (ACC_W saturating add)
  - rnd_sat helper (shift/round/saturate)
  - drain-state encoding (EMPTY, LOCAL)
- One sub-module, pe_requant: combinational round-and-saturate from ACC_W to DATA_W. It is reused by the array edge logic.

Test Plan:
- Forwarding: in_a=0x1234, in_b=0xABCD, in_valid=1, one cycle -> out_a=0x1234, out_b=0xABCD, out_valid=1 on the next edge; also check that reset clears them asynchronously (without waiting for a clock edge).
- Dot product: 4 beats a=0x0100, b=0x0200, first on beat 0, last on beat 3, drain_out_ready=1 -> drain_out_data=0x0800, drain_out_valid 2 cycles after last (3 with MULT_PIPE=1).
- Rounding/sign: single beat (first and last) a=0x0001, b=0x0080 -> 0x0001; a=0xFFFF, b=0x0080 -> 0x0000; a=0xFFFF, b=0xFF80 -> 0x0001.
- Saturation: a=b=0x7FFF single beat -> 0x7FFF, sat_flag=1; a=0x8000, b=0x7FFF -> 0x8000, sat_flag=1.
- Drain chain with backpressure: local res pending and upstream valid=0x0055, drain_out_ready low 3 cycles -> drain_out holds local value stably and drain_in_ready=0; after release, local emitted first, then 0x0055.
- Overflow and reset: two 1-beat dot products while drain_out_ready=0 with the output register full -> second dropped, ovr_flag=1; assert rst mid-accumulation -> all outputs 0, then the next dot product computes from zero.
